// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the core's memory blocks.
//   DMEM_RSP_t      : one data memory response {data, write, err}; data is
//                     sized for the widest supported word and zero-extended
//                     for narrower memories.
//   DMEM_RD_LAT_MAX : largest supported data memory read latency.
package singlecycle_pkg;

   localparam int DMEM_RD_LAT_MAX = 4;
   localparam int DMEM_DATA_W_MAX = 64;

   typedef struct packed {
      logic [DMEM_DATA_W_MAX-1:0] data;
      logic                       write;
      logic                       err;
   } DMEM_RSP_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO for data_mem_pipe.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (pointers and count only)
//   i_push, i_data : write one response
//   i_pop          : remove the head response (ignored when empty)
//   o_data         : head response (only meaningful while o_valid=1)
//   o_valid        : FIFO holds at least one response
// The caller guarantees no push into a full FIFO via its credit counter.
module rsp_fifo
   import singlecycle_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_push,
   input  DMEM_RSP_t i_data,
   input  logic      i_pop,
   output DMEM_RSP_t o_data,
   output logic      o_valid
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   DMEM_RSP_t        store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             pop;

   assign o_valid = (count != '0);
   assign pop     = i_pop & o_valid;
   assign o_data  = store[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_push) store[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (i_push && !pop)      count <= count + 1'b1;
         else if (!i_push && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined flop-based data memory with in-order response channel.
// Every accepted request (read or write) yields exactly one response.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_VALID/o_READY         : request handshake
//   i_ADDR, i_WREN          : byte address, 1=write
//   i_WDATA, i_BMASK        : write data and byte enables
//   o_RVALID/i_RREADY       : response handshake
//   o_RDATA, o_RWRITE, o_RERR : response payload, all 0 while o_RVALID=0
// Optional feature macro: DMEM_ERR_CHECK_EN -- flags misaligned requests and
// writes with an empty byte mask; such requests are answered with o_RERR=1
// and leave memory untouched. Without it, low address bits are ignored.
module data_mem_pipe
   import singlecycle_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 18,
   parameter int RD_LAT    = 1,
   parameter int RSP_DEPTH = 4
)(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_VALID,
   output logic                o_READY,
   input  logic [ADDR_W-1:0]   i_ADDR,
   input  logic                i_WREN,
   input  logic [DATA_W-1:0]   i_WDATA,
   input  logic [DATA_W/8-1:0] i_BMASK,
   output logic                o_RVALID,
   input  logic                i_RREADY,
   output logic [DATA_W-1:0]   o_RDATA,
   output logic                o_RWRITE,
   output logic                o_RERR
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam int WORDS = 2 ** IDX_W;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int LAT_C = (RD_LAT > DMEM_RD_LAT_MAX) ? DMEM_RD_LAT_MAX : RD_LAT;

   logic [DATA_W-1:0] mem [WORDS];
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              pop;
   logic              push;
   logic              req_err;
   logic              fifo_vld;
   logic              rsp_unused;
   DMEM_RSP_t         req_rsp;
   DMEM_RSP_t         push_rsp;
   DMEM_RSP_t         fifo_rsp;

   assign accept  = i_VALID & o_READY;
   assign pop     = fifo_vld & i_RREADY;
   assign idx     = i_ADDR[ADDR_W-1:OFF_W];
   // cnt covers in-flight stages as well as FIFO entries, so a full credit
   // count guarantees the FIFO can absorb everything already issued.
   assign o_READY = (cnt < CNT_W'(RSP_DEPTH));

`ifdef DMEM_ERR_CHECK_EN
   logic [ADDR_W-1:0] lo_mask;
   assign lo_mask = ADDR_W'((1 << OFF_W) - 1);
   assign req_err = (|(i_ADDR & lo_mask)) | (i_WREN & ~(|i_BMASK));
`else
   assign req_err = 1'b0;
`endif

   // Read data is captured on the accept edge; writes and reads are separate
   // requests, so an earlier write is always visible here.
   always_comb begin
      req_rsp       = '0;
      req_rsp.write = i_WREN;
      req_rsp.err   = req_err;
      if (!i_WREN && !req_err) req_rsp.data = DMEM_DATA_W_MAX'(mem[idx]);
   end

   always_ff @(posedge i_clk) begin
      if (accept && i_WREN && !req_err) begin
         for (int b = 0; b < BYTES; b++) begin
            if (i_BMASK[b]) mem[idx][8*b +: 8] <= i_WDATA[8*b +: 8];
         end
      end
   end

   generate
      if (LAT_C == 1) begin : g_lat1
         assign push     = accept;
         assign push_rsp = req_rsp;
      end else begin : g_stages
         logic [LAT_C-2:0] st_vld;
         DMEM_RSP_t        st_rsp [LAT_C-1];

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               st_vld <= '0;
               for (int s = 0; s < LAT_C - 1; s++) st_rsp[s] <= '0;
            end else begin
               st_vld[0] <= accept;
               st_rsp[0] <= req_rsp;
               for (int s = 1; s < LAT_C - 1; s++) begin
                  st_vld[s] <= st_vld[s-1];
                  st_rsp[s] <= st_rsp[s-1];
               end
            end
         end

         assign push     = st_vld[LAT_C-2];
         assign push_rsp = st_rsp[LAT_C-2];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)            cnt <= '0;
      else if (accept && !pop) cnt <= cnt + 1'b1;
      else if (!accept && pop) cnt <= cnt - 1'b1;
   end

   rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (push_rsp),
      .i_pop   (pop),
      .o_data  (fifo_rsp),
      .o_valid (fifo_vld)
   );

   assign o_RVALID   = fifo_vld;
   assign o_RDATA    = fifo_vld ? fifo_rsp.data[DATA_W-1:0] : '0;
   assign o_RWRITE   = fifo_vld & fifo_rsp.write;
   assign o_RERR     = fifo_vld & fifo_rsp.err;
   // Upper response bits and ignored address bits are intentionally dropped.
   assign rsp_unused = ^{fifo_rsp.data, i_ADDR};

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: two instances (read latency 1 and 3), each driven
// by its own stimulus and checked every cycle against a queue-based model.
module tb_data_mem_pipe;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 12;
   localparam int RSP_DEPTH = 4;
   localparam int NLANE     = 2;
   localparam int NWORDS    = 16;
   localparam logic [ADDR_W-1:0] BASE = 12'h100;
`ifdef DMEM_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        write;
      logic        err;
      int          e;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit done [NLANE];

   task automatic chk(input string name, input int lane, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane=%0d got=0x%0h want=0x%0h", name, lane, act, exp);
      end
   endtask

   task automatic bound_fail(input string name, input int lane);
      checks++;
      errors++;
      $display("FAIL %s lane=%0d got=timeout want=event", name, lane);
   endtask

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      localparam int LAT = (g == 0) ? 1 : 3;

      logic              rst_n, valid, wren, rready;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        bmask;
      logic              ready, rvalid, rwrite, rerr;
      logic [31:0]       rdata;

      data_mem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT),
                      .RSP_DEPTH(RSP_DEPTH)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_VALID(valid), .o_READY(ready),
         .i_ADDR(addr), .i_WREN(wren), .i_WDATA(wdata), .i_BMASK(bmask),
         .o_RVALID(rvalid), .i_RREADY(rready), .o_RDATA(rdata),
         .o_RWRITE(rwrite), .o_RERR(rerr));

      // Model: word array plus a queue of outstanding responses, each tagged
      // with the edge after which it becomes visible.
      logic [31:0] mm [NWORDS];
      rsp_t        q [$];
      rsp_t        log_q [$];
      int          ecnt = 0;
      bit          mready, ev;
      rsp_t        r;
      int          wi;

      function automatic logic is_err(input logic w, input logic [ADDR_W-1:0] a,
                                      input logic [3:0] m);
         return ERR_EN && ((a[1:0] != 2'b00) || (w && m == 4'h0));
      endfunction

      always @(posedge clk) begin
         ecnt++;
         if (rst_n) begin
            mready = (q.size() < RSP_DEPTH);
            if (q.size() > 0 && rready) begin
               if (q[0].e <= ecnt - 1) void'(q.pop_front());
            end
            if (valid && mready) begin
               wi      = int'(addr >> 2) - int'(BASE >> 2);
               r.err   = is_err(wren, addr, bmask);
               r.write = wren;
               r.data  = 32'h0;
               r.e     = ecnt + LAT - 1;
               if (!r.err) begin
                  if (wren) begin
                     for (int b = 0; b < 4; b++) begin
                        if (bmask[b]) mm[wi][8*b +: 8] = wdata[8*b +: 8];
                     end
                  end else begin
                     r.data = mm[wi];
                  end
               end
               q.push_back(r);
            end
         end
      end

      always @(negedge clk) begin
         ev = (q.size() > 0) && (q[0].e <= ecnt);
         chk("ready",  g, 64'(ready),  64'(q.size() < RSP_DEPTH));
         chk("rvalid", g, 64'(rvalid), 64'(ev));
         chk("rdata",  g, 64'(rdata),  ev ? 64'(q[0].data)  : 64'h0);
         chk("rwrite", g, 64'(rwrite), ev ? 64'(q[0].write) : 64'h0);
         chk("rerr",   g, 64'(rerr),   ev ? 64'(q[0].err)   : 64'h0);
         if (rvalid && rready) log_q.push_back('{rdata, rwrite, rerr, ecnt});
      end

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] m, output int acc);
         bit rdy;
         valid = 1'b1; wren = w; addr = a; wdata = d; bmask = m; acc = -1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = ready;
            tick();
            if (rdy) begin
               acc = ecnt;
               break;
            end
         end
         valid = 1'b0;
         if (acc < 0) bound_fail("accept_timeout", g);
      endtask

      task automatic wait_log(input int n, output bit ok);
         for (int i = 0; i < 60 && log_q.size() < n; i++) tick();
         ok = (log_q.size() >= n);
         if (!ok) bound_fail("response_timeout", g);
      endtask

      task automatic wait_idle();
         for (int i = 0; i < 60 && q.size() > 0; i++) tick();
         if (q.size() > 0) bound_fail("drain_timeout", g);
      endtask

      initial begin
         int  acc, a1, n_acc;
         bit  ok, rdy, pending;
         rst_n = 1'b0; valid = 1'b0; wren = 1'b0; addr = '0;
         wdata = '0; bmask = '0; rready = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;
         chk("reset_ready",  g, 64'(ready),  64'd1);
         chk("reset_rvalid", g, 64'(rvalid), 64'd0);
         chk("reset_rdata",  g, 64'(rdata),  64'd0);

         rready = 1'b1;
         for (int i = 0; i < NWORDS; i++)
            send(1'b1, BASE + ADDR_W'(4 * i), $urandom, 4'hF, acc);
         wait_idle();
         tick();
         log_q.delete();

         // Full-word write then read back.
         send(1'b1, 12'h100, 32'hDEADBEEF, 4'hF, acc);
         send(1'b0, 12'h100, 32'h0, 4'h0, a1);
         wait_log(2, ok);
         if (ok) begin
            chk("A_wr_flag", g, 64'(log_q[0].write), 64'd1);
            chk("A_wr_data", g, 64'(log_q[0].data),  64'd0);
            chk("A_rd_data", g, 64'(log_q[1].data),  64'hDEADBEEF);
            chk("A_rd_lat",  g, 64'(log_q[1].e - a1), 64'(LAT - 1));
         end
         tick();
         log_q.delete();

         // Single-byte write merges into the existing word.
         send(1'b1, 12'h100, 32'h000000AA, 4'h1, acc);
         send(1'b0, 12'h100, 32'h0, 4'h0, acc);
         wait_log(2, ok);
         if (ok) chk("B_rd_data", g, 64'(log_q[1].data), 64'hDEADBEAA);
         tick();
         log_q.delete();

         // Back-to-back write/read pairs, one response per cycle.
         send(1'b1, 12'h120, 32'h01234567, 4'hF, acc);
         send(1'b0, 12'h120, 32'h0, 4'h0, acc);
         send(1'b1, 12'h120, 32'h89ABCDEF, 4'hF, acc);
         send(1'b0, 12'h120, 32'h0, 4'h0, acc);
         wait_log(4, ok);
         if (ok) begin
            chk("D_rd0",     g, 64'(log_q[1].data), 64'h01234567);
            chk("D_rd1",     g, 64'(log_q[3].data), 64'h89ABCDEF);
            chk("D_spacing", g, 64'(log_q[3].e - log_q[0].e), 64'd3);
         end
         tick();
         log_q.delete();

         // Fill the response path with the consumer stalled.
         for (int i = 0; i < 4; i++)
            send(1'b1, 12'h104 + ADDR_W'(4 * i), 32'hC0DE0001 + i, 4'hF, acc);
         wait_idle();
         tick();
         log_q.delete();
         rready = 1'b0;
         n_acc  = 0;
         for (int i = 0; i < 8; i++) begin
            valid = 1'b1; wren = 1'b0; addr = 12'h104 + ADDR_W'(4 * n_acc);
            @(negedge clk);
            rdy = ready;
            tick();
            if (rdy) n_acc++;
         end
         valid = 1'b0;
         chk("C_accepts",   g, 64'(n_acc), 64'd4);
         chk("C_ready_low", g, 64'(ready), 64'd0);
         rready = 1'b1;
         tick();
         chk("C_ready_back", g, 64'(ready), 64'd1);
         wait_log(4, ok);
         if (ok) begin
            for (int i = 0; i < 4; i++)
               chk("C_order", g, 64'(log_q[i].data), 64'(32'hC0DE0001 + i));
         end
         tick();
         log_q.delete();

         // Misaligned write: flagged with the check enabled, aliased otherwise.
         send(1'b1, 12'h102, 32'h11223344, 4'hF, acc);
         send(1'b0, 12'h100, 32'h0, 4'h0, acc);
         wait_log(2, ok);
         if (ok) begin
`ifdef DMEM_ERR_CHECK_EN
            chk("E_wr_err",  g, 64'(log_q[0].err),  64'd1);
            chk("E_rd_data", g, 64'(log_q[1].data), 64'hDEADBEAA);
`else
            chk("E_wr_err",  g, 64'(log_q[0].err),  64'd0);
            chk("E_rd_data", g, 64'(log_q[1].data), 64'h11223344);
`endif
         end

         // Randomised traffic; a stalled request is held unchanged.
         pending = 1'b0;
         for (int i = 0; i < 400; i++) begin
            if (!pending) begin
               valid = ($urandom_range(0, 3) != 0);
               wren  = 1'($urandom_range(0, 1));
               addr  = BASE + ADDR_W'($urandom_range(0, 4 * NWORDS - 1));
               wdata = $urandom;
               bmask = 4'($urandom_range(0, 15));
            end
            rready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rdy = ready;
            tick();
            pending = valid && !rdy;
         end
         valid  = 1'b0;
         rready = 1'b1;
         wait_idle();
         tick();

         // Reset with three responses queued discards them all.
         rready = 1'b0;
         for (int i = 0; i < 3; i++) send(1'b0, 12'h104 + ADDR_W'(4 * i), 32'h0, 4'h0, acc);
         repeat (LAT) tick();
         #1;
         rst_n = 1'b0;
         q.delete();
         #1;
         chk("F_rvalid", g, 64'(rvalid), 64'd0);
         chk("F_ready",  g, 64'(ready),  64'd1);
         log_q.delete();
         repeat (3) tick();
         @(negedge clk);
         #1 rst_n = 1'b1;
         rready = 1'b1;
         repeat (10) tick();
         chk("F_no_stale", g, 64'(log_q.size()), 64'd0);
         send(1'b0, 12'h104, 32'h0, 4'h0, acc);
         wait_log(1, ok);
         tick();
         done[g] = 1'b1;
      end
   end

   initial begin
      wait (done[0] && done[1]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
